// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm / chime controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHIME  = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  // BCD field widths for HH:MM:SS
  localparam int HH_W = 2;
  localparam int HL_W = 4;
  localparam int MH_W = 3;
  localparam int ML_W = 4;
  localparam int SH_W = 3;
  localparam int SL_W = 4;

  // True when HH:MM is a legal 24-hour BCD time (00:00 .. 23:59)
  function automatic logic hhmm_valid(input logic [HH_W-1:0] hh,
                                      input logic [HL_W-1:0] hl,
                                      input logic [MH_W-1:0] mh,
                                      input logic [ML_W-1:0] ml);
    hhmm_valid = (hl <= 4'd9) && (ml <= 4'd9) && (mh <= 3'd5) &&
                 (hh <= 2'd2) && !((hh == 2'd2) && (hl > 4'd3));
  endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// Rhythmic buzzer drive: bursts of a 500 Hz tone aligned to the second.
module beep_pattern_gen import alarm_pkg::*; #(
  parameter int BEEPS_PER_SEC = 3,
  parameter int BEEP_MS       = 100
) (
  input  logic clk_1khz,
  input  logic switch_clr,
  input  logic tick_1hz,
  input  logic enable,
  output logic beep
);

  localparam int PAT_END = 2 * BEEP_MS * BEEPS_PER_SEC;

  logic [9:0] ms_cnt;
  logic       tone;
  logic       pattern;

  // Millisecond counter, realigned to 0 on every second strobe
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr)            ms_cnt <= '0;
    else if (tick_1hz)          ms_cnt <= '0;
    else if (ms_cnt == 10'd999) ms_cnt <= '0;
    else                        ms_cnt <= ms_cnt + 10'd1;
  end

  // Burst window: even-numbered BEEP_MS slots inside the burst region
  always_comb begin
    pattern = (int'(ms_cnt) < PAT_END) && (((int'(ms_cnt) / BEEP_MS) % 2) == 0);
  end

  // 500 Hz carrier and registered buzzer output
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      tone <= 1'b0;
      beep <= 1'b0;
    end else begin
      tone <= ~tone;
      beep <= pattern & tone & enable;
    end
  end

endmodule

// File: rtl/alarm_chime_ctrl.sv
// Alarm and hourly chime controller: N programmable HH:MM alarms,
// snooze handling, missed-alarm flags and buzzer pattern.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | quiet, watching for alarm or chime matches
// CHIME   | hourly chime sounding for CHIME_SEC seconds
// RING    | alarm active_idx ringing, timeout after RING_SEC
// SNOOZE  | alarm active_idx silenced for SNOOZE_SEC seconds
module alarm_chime_ctrl import alarm_pkg::*; #(
  parameter int N_ALARMS      = 4,
  parameter int RING_SEC      = 60,
  parameter int SNOOZE_SEC    = 300,
  parameter int MAX_SNOOZE    = 3,
  parameter int CHIME_SEC     = 5,
  parameter int BEEPS_PER_SEC = 3,
  parameter int BEEP_MS       = 100,
  parameter int IW            = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk_1khz,
  input  logic                switch_clr,
  input  logic                tick_1hz,
  input  logic [HH_W-1:0]     cur_hh,
  input  logic [HL_W-1:0]     cur_hl,
  input  logic [MH_W-1:0]     cur_mh,
  input  logic [ML_W-1:0]     cur_ml,
  input  logic [SH_W-1:0]     cur_sh,
  input  logic [SL_W-1:0]     cur_sl,
  input  logic                chime_en,
  input  logic                debug_force,
  input  logic                btn_ack_raw,
  input  logic                btn_snooze_raw,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic                wr_enable,
  input  logic [HH_W-1:0]     wr_hh,
  input  logic [HL_W-1:0]     wr_hl,
  input  logic [MH_W-1:0]     wr_mh,
  input  logic [ML_W-1:0]     wr_ml,
  output logic                wr_err,
  output logic                beep,
  output logic [1:0]          state,
  output logic [IW-1:0]       active_idx,
  output logic [N_ALARMS-1:0] missed
);

  localparam int TMR_MAX = (RING_SEC > CHIME_SEC) ? RING_SEC : CHIME_SEC;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int SW      = $clog2(SNOOZE_SEC + 1);
  localparam int CW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  state_t              state_q, state_nxt;
  logic [TW-1:0]       ring_tmr;
  logic [SW-1:0]       snz_tmr;
  logic [CW-1:0]       snz_cnt;

  logic                al_en [N_ALARMS];
  logic [HH_W-1:0]     al_hh [N_ALARMS];
  logic [HL_W-1:0]     al_hl [N_ALARMS];
  logic [MH_W-1:0]     al_mh [N_ALARMS];
  logic [ML_W-1:0]     al_ml [N_ALARMS];

  logic                ack_s1, ack_s2, ack_prev, snz_s1, snz_s2, snz_prev;
  logic                ack_evt, snz_evt;
  logic                wr_ok, wr_acc, dis_active;
  logic [N_ALARMS-1:0] match, set_mask, clr_mask;
  logic [IW-1:0]       win_idx;
  logic                any_match, chime_match;
  logic                new_ring, ld_ring, ld_chime, ld_snooze, timeout;
  logic                beep_en;

  // Button synchronisers with rising-edge detect
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      {ack_s1, ack_s2, ack_prev} <= '0;
      {snz_s1, snz_s2, snz_prev} <= '0;
    end else begin
      ack_s1   <= btn_ack_raw;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
      snz_s1   <= btn_snooze_raw;
      snz_s2   <= snz_s1;
      snz_prev <= snz_s2;
    end
  end

  assign ack_evt = ack_s2 & ~ack_prev;
  assign snz_evt = snz_s2 & ~snz_prev;

  assign wr_ok      = hhmm_valid(wr_hh, wr_hl, wr_mh, wr_ml) && (int'(wr_idx) < N_ALARMS);
  assign wr_acc     = wr_en & wr_ok;
  assign dis_active = wr_acc && (wr_idx == active_idx) && !wr_enable;

  // Per-channel alarm compare against the running time
  always_comb begin
    match = '0;
    for (int i = 0; i < N_ALARMS; i++)
      match[i] = tick_1hz && al_en[i] &&
                 (al_hh[i] == cur_hh) && (al_hl[i] == cur_hl) &&
                 (al_mh[i] == cur_mh) && (al_ml[i] == cur_ml) &&
                 (cur_sh == '0) && (cur_sl == '0);
  end

  // Lowest matching channel wins
  always_comb begin
    win_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (match[i]) win_idx = IW'(i);
  end

  assign any_match   = |match;
  assign chime_match = tick_1hz && chime_en && (cur_mh == '0) && (cur_ml == '0) &&
                       (cur_sh == '0) && (cur_sl == '0);

  // FSM state register
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) state_q <= ST_IDLE;
    else             state_q <= state_nxt;
  end

  // FSM next-state and load controls
  always_comb begin
    state_nxt = state_q;
    new_ring  = 1'b0;
    ld_ring   = 1'b0;
    ld_chime  = 1'b0;
    ld_snooze = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE, ST_CHIME: begin
        if (any_match) begin
          state_nxt = ST_RING;
          new_ring  = 1'b1;
          ld_ring   = 1'b1;
        end else if (state_q == ST_IDLE && chime_match) begin
          state_nxt = ST_CHIME;
          ld_chime  = 1'b1;
        end else if (state_q == ST_CHIME && tick_1hz && ring_tmr <= TW'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RING: begin
        if (dis_active || ack_evt) begin
          state_nxt = ST_IDLE;
        end else if (snz_evt) begin
          if (int'(snz_cnt) < MAX_SNOOZE) begin
            state_nxt = ST_SNOOZE;
            ld_snooze = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (tick_1hz && ring_tmr <= TW'(1)) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (dis_active || ack_evt) begin
          state_nxt = ST_IDLE;
        end else if (tick_1hz && snz_tmr <= SW'(1)) begin
          state_nxt = ST_RING;
          ld_ring   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    state   = state_q;
    beep_en = (state_q == ST_CHIME) || (state_q == ST_RING) || debug_force;
  end

  // Second-based down-counters, ringing channel and snooze count
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      ring_tmr   <= '0;
      snz_tmr    <= '0;
      snz_cnt    <= '0;
      active_idx <= '0;
    end else begin
      if (ld_ring)       ring_tmr <= TW'(RING_SEC);
      else if (ld_chime) ring_tmr <= TW'(CHIME_SEC);
      else if (tick_1hz && ring_tmr != '0 &&
               (state_q == ST_CHIME || state_q == ST_RING))
        ring_tmr <= ring_tmr - TW'(1);

      if (ld_snooze) snz_tmr <= SW'(SNOOZE_SEC);
      else if (tick_1hz && snz_tmr != '0 && state_q == ST_SNOOZE)
        snz_tmr <= snz_tmr - SW'(1);

      if (new_ring) begin
        active_idx <= win_idx;
        snz_cnt    <= '0;
      end else if (ld_snooze) begin
        snz_cnt <= snz_cnt + CW'(1);
      end
    end
  end

  // Missed flags: unserviced matches and ring timeouts set, accepted writes clear
  always_comb begin
    if (state_q == ST_RING || state_q == ST_SNOOZE)
      set_mask = match & ~(N_ALARMS'(1) << active_idx);
    else
      set_mask = match & ~(N_ALARMS'(1) << win_idx);
    if (timeout) set_mask = set_mask | (N_ALARMS'(1) << active_idx);
    clr_mask = '0;
    if (wr_acc) clr_mask = N_ALARMS'(1) << wr_idx;
  end

  // Alarm register file, write error pulse and missed flags
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        al_en[i] <= 1'b0;
        al_hh[i] <= '0;
        al_hl[i] <= '0;
        al_mh[i] <= '0;
        al_ml[i] <= '0;
      end
      wr_err <= 1'b0;
      missed <= '0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      for (int i = 0; i < N_ALARMS; i++) begin
        if (wr_acc && wr_idx == IW'(i)) begin
          al_en[i] <= wr_enable;
          al_hh[i] <= wr_hh;
          al_hl[i] <= wr_hl;
          al_mh[i] <= wr_mh;
          al_ml[i] <= wr_ml;
        end
      end
      missed <= (missed & ~clr_mask) | set_mask;
    end
  end

  beep_pattern_gen #(
    .BEEPS_PER_SEC (BEEPS_PER_SEC),
    .BEEP_MS       (BEEP_MS)
  ) u_beep (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .tick_1hz   (tick_1hz),
    .enable     (beep_en),
    .beep       (beep)
  );

endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// Scoreboard bench for alarm_chime_ctrl: stimulus queues expectations,
// a monitor compares them at the falling edge.
module tb_alarm_chime_ctrl;

  localparam int IW = 2;
  localparam int K_STATE = 0, K_IDX = 1, K_MISS = 2, K_BEEP = 3, K_CNT = 4, K_SYNC = 5;
  localparam int S_IDLE = 0, S_CHIME = 1, S_RING = 2, S_SNOOZE = 3;

  logic          clk_1khz = 1'b0;
  logic          switch_clr = 1'b0;
  logic          tick_1hz = 1'b0;
  logic [1:0]    cur_hh = '0;
  logic [3:0]    cur_hl = '0;
  logic [2:0]    cur_mh = '0;
  logic [3:0]    cur_ml = '0;
  logic [2:0]    cur_sh = '0;
  logic [3:0]    cur_sl = '0;
  logic          chime_en = 1'b0;
  logic          debug_force = 1'b0;
  logic          btn_ack_raw = 1'b0;
  logic          btn_snooze_raw = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic          wr_enable = 1'b0;
  logic [1:0]    wr_hh = '0;
  logic [3:0]    wr_hl = '0;
  logic [2:0]    wr_mh = '0;
  logic [3:0]    wr_ml = '0;
  logic          wr_err;
  logic          beep;
  logic [1:0]    state;
  logic [IW-1:0] active_idx;
  logic [3:0]    missed;

  always #5 clk_1khz = ~clk_1khz;

  alarm_chime_ctrl dut (
    .clk_1khz       (clk_1khz),
    .switch_clr     (switch_clr),
    .tick_1hz       (tick_1hz),
    .cur_hh         (cur_hh),
    .cur_hl         (cur_hl),
    .cur_mh         (cur_mh),
    .cur_ml         (cur_ml),
    .cur_sh         (cur_sh),
    .cur_sl         (cur_sl),
    .chime_en       (chime_en),
    .debug_force    (debug_force),
    .btn_ack_raw    (btn_ack_raw),
    .btn_snooze_raw (btn_snooze_raw),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .wr_enable      (wr_enable),
    .wr_hh          (wr_hh),
    .wr_hl          (wr_hl),
    .wr_mh          (wr_mh),
    .wr_ml          (wr_ml),
    .wr_err         (wr_err),
    .beep           (beep),
    .state          (state),
    .active_idx     (active_idx),
    .missed         (missed)
  );

  typedef struct {
    string name;
    int    kind;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   wr_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_1khz);
      #1;
    end
  endtask

  task automatic expect_v(input string name, input int kind, input int val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic set_time(input int hh, input int hl, input int mh, input int ml,
                          input int sh, input int sl);
    cur_hh = 2'(hh); cur_hl = 4'(hl); cur_mh = 3'(mh);
    cur_ml = 4'(ml); cur_sh = 3'(sh); cur_sl = 4'(sl);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      cyc();
    end
  endtask

  task automatic write_al(input int idx, input bit en, input int hh, input int hl,
                          input int mh, input int ml, input int exp_err);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_enable = en;
    wr_hh = 2'(hh); wr_hl = 4'(hl); wr_mh = 3'(mh); wr_ml = 4'(ml);
    wr_q.push_back(exp_err);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic press(input bit a, input bit s);
    btn_ack_raw = a;
    btn_snooze_raw = s;
    cyc(3);
    btn_ack_raw = 1'b0;
    btn_snooze_raw = 1'b0;
    cyc(3);
  endtask

  // Monitor: compares queued expectations and write responses at the falling edge
  initial begin : monitor
    int   beep_cnt;
    logic wr_pend;
    exp_t e;
    int   ex;
    beep_cnt = 0;
    forever begin
      @(posedge clk_1khz);
      wr_pend = wr_en;
      @(negedge clk_1khz);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_STATE: check(e.name, int'(state), e.val);
          K_IDX:   check(e.name, int'(active_idx), e.val);
          K_MISS:  check(e.name, int'(missed), e.val);
          K_BEEP:  check(e.name, int'(beep), e.val);
          K_CNT: begin
            check(e.name, beep_cnt, e.val);
            beep_cnt = 0;
          end
          default: beep_cnt = 0;
        endcase
      end
      if (beep) beep_cnt++;
      if (wr_pend) begin
        ex = (wr_q.size() > 0) ? wr_q.pop_front() : 0;
        check("wr_err", int'(wr_err), ex);
      end else if (wr_err) begin
        errors++;
        checks++;
        $display("FAIL wr_err_spurious: got 1 expected 0");
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // reset values
    cyc(3);
    expect_v("rst_state", K_STATE, S_IDLE);
    expect_v("rst_idx", K_IDX, 0);
    expect_v("rst_missed", K_MISS, 0);
    expect_v("rst_beep", K_BEEP, 0);
    switch_clr = 1'b1;
    cyc(2);

    // writes: one good, then illegal ones that must leave ch1 untouched
    write_al(1, 1, 0, 7, 3, 0, 0);
    write_al(1, 1, 2, 4, 0, 0, 1);
    write_al(1, 1, 0, 7, 6, 0, 1);
    write_al(1, 1, 0, 7, 3, 10, 1);
    write_al(1, 1, 3, 0, 0, 0, 1);
    cyc(2);

    // quiet in IDLE
    expect_v("idle_sync", K_SYNC, 0);
    cyc(100);
    expect_v("idle_quiet", K_CNT, 0);

    // ch1 07:30 rings
    set_time(0, 7, 2, 9, 5, 9);
    tick();
    expect_v("pre_alarm_state", K_STATE, S_IDLE);
    set_time(0, 7, 3, 0, 0, 0);
    tick();
    expect_v("ring1_state", K_STATE, S_RING);
    expect_v("ring1_idx", K_IDX, 1);
    cyc();
    expect_v("beep_sync", K_SYNC, 0);
    for (int w = 0; w < 10; w++) begin
      cyc(100);
      expect_v($sformatf("beep_win%0d", w), K_CNT, (w == 0 || w == 2 || w == 4) ? 50 : 0);
    end

    // snooze three times, fourth snooze acts as ack
    set_time(0, 7, 3, 0, 0, 5);
    for (int s = 1; s <= 3; s++) begin
      press(0, 1);
      expect_v($sformatf("snooze%0d_state", s), K_STATE, S_SNOOZE);
      expect_v("snooze_sync", K_SYNC, 0);
      cyc(50);
      expect_v($sformatf("snooze%0d_quiet", s), K_CNT, 0);
      ticks(299);
      expect_v($sformatf("snooze%0d_wait", s), K_STATE, S_SNOOZE);
      ticks(1);
      expect_v($sformatf("resume%0d_state", s), K_STATE, S_RING);
      expect_v($sformatf("resume%0d_idx", s), K_IDX, 1);
    end
    press(0, 1);
    expect_v("snooze4_ack", K_STATE, S_IDLE);
    expect_v("snooze_missed", K_MISS, 0);

    // ch0 and ch2 both 12:00
    write_al(0, 1, 1, 2, 0, 0, 0);
    write_al(2, 1, 1, 2, 0, 0, 0);
    set_time(1, 2, 0, 0, 0, 0);
    tick();
    expect_v("dual_state", K_STATE, S_RING);
    expect_v("dual_idx", K_IDX, 0);
    expect_v("dual_missed", K_MISS, 4'b0100);
    write_al(0, 1, 1, 2, 0, 0, 0);
    expect_v("rewrite_active_state", K_STATE, S_RING);
    write_al(2, 1, 1, 2, 0, 0, 0);
    expect_v("rewrite_missed", K_MISS, 0);
    press(1, 1);
    expect_v("ack_beats_snooze", K_STATE, S_IDLE);

    // hourly chime
    chime_en = 1'b1;
    set_time(1, 4, 5, 9, 5, 9);
    tick();
    expect_v("pre_chime", K_STATE, S_IDLE);
    set_time(1, 5, 0, 0, 0, 0);
    tick();
    expect_v("chime_start", K_STATE, S_CHIME);
    set_time(1, 5, 0, 0, 0, 1);
    ticks(4);
    expect_v("chime_4ticks", K_STATE, S_CHIME);
    ticks(1);
    expect_v("chime_end", K_STATE, S_IDLE);

    // alarm at 15:00 preempts chime, then times out
    write_al(3, 1, 1, 5, 0, 0, 0);
    set_time(1, 5, 0, 0, 0, 0);
    tick();
    expect_v("alarm_over_chime", K_STATE, S_RING);
    expect_v("alarm_over_chime_idx", K_IDX, 3);
    set_time(1, 5, 0, 0, 0, 1);
    ticks(59);
    expect_v("ring_59", K_STATE, S_RING);
    ticks(1);
    expect_v("ring_timeout", K_STATE, S_IDLE);
    expect_v("ring_timeout_missed", K_MISS, 4'b1000);

    // disabling the ringing channel stops it and clears its missed flag
    chime_en = 1'b0;
    set_time(1, 5, 0, 0, 0, 0);
    tick();
    expect_v("ring3_again", K_STATE, S_RING);
    write_al(3, 0, 1, 5, 0, 0, 0);
    expect_v("disable_active", K_STATE, S_IDLE);
    expect_v("disable_missed", K_MISS, 0);
    write_al(3, 1, 1, 5, 0, 0, 0);
    tick();
    expect_v("ring3_reenabled", K_STATE, S_RING);

    // reset while ringing, taken while the buzzer is high
    for (int k = 0; k < 50 && !beep; k++) cyc();
    if (!beep) expect_v("beep_wait", K_BEEP, 1);
    switch_clr = 1'b0;
    expect_v("midrst_state", K_STATE, S_IDLE);
    expect_v("midrst_beep", K_BEEP, 0);
    expect_v("midrst_idx", K_IDX, 0);
    cyc(2);
    switch_clr = 1'b1;
    cyc(2);
    tick();
    expect_v("cleared_1500", K_STATE, S_IDLE);
    set_time(1, 2, 0, 0, 0, 0);
    tick();
    expect_v("cleared_1200", K_STATE, S_IDLE);

    // debug_force beeps in IDLE
    debug_force = 1'b1;
    set_time(0, 9, 1, 2, 3, 4);
    tick();
    cyc();
    expect_v("dbg_sync", K_SYNC, 0);
    cyc(100);
    expect_v("dbg_burst", K_CNT, 50);
    cyc(100);
    expect_v("dbg_gap", K_CNT, 0);
    debug_force = 1'b0;

    cyc(3);
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size() + wr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
